// File: rtl/ap_divi.sv
// rtl/ap_divi.sv - multi-cycle radix-2 restoring integer divider
//
// Purpose: computes c_out = a_in / b_in and r_out = a_in % b_in over WIDTH+2
//   clock edges from the accepted start, with a start/valid handshake.
//   SIGNED=1 divides two's-complement operands, truncating toward zero.
//   SIGNED=0 divides unsigned operands.
//   Divide by zero returns c_out = all ones and r_out = a_in.
//   most_negative / -1 wraps to c_out = most_negative and r_out = 0.
//
// Optional feature: define AP_DIV_ZERO_FLAG_EN to add dz_out, which flags
//   results whose divisor was zero.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   request, sampled only while ready_out=1
//   a_in       in   dividend, captured on the accepted start
//   b_in       in   divisor, captured on the accepted start
//   ready_out  out  1 = idle, a start this cycle is accepted
//   valid_out  out  one-cycle pulse, c_out/r_out just updated
//   c_out      out  quotient, held between results
//   r_out      out  remainder, held between results
//   dz_out     out  (AP_DIV_ZERO_FLAG_EN only) divisor of last result was zero

module ap_divi #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] c_out,
`ifdef AP_DIV_ZERO_FLAG_EN
  output logic [WIDTH-1:0] r_out,
  output logic             dz_out
`else
  output logic [WIDTH-1:0] r_out
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             valid_q, valid_d;
`ifdef AP_DIV_ZERO_FLAG_EN
  logic             bzero_q, bzero_d;
  logic             dz_q, dz_d;
`endif

  // Operand conditioning for the capture cycle.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_neg  = SIGNED && a_in[WIDTH-1];
    b_neg  = SIGNED && b_in[WIDTH-1];
    a_mag  = a_neg ? (~a_in + 1'b1) : a_in;
    b_mag  = b_neg ? (~b_in + 1'b1) : b_in;
    b_zero = (b_in == '0);
  end

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor.
  // The trial is one bit wider than the partial remainder so its MSB is
  // the borrow.
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic             unused_trial_bit;

  always_comb begin
    partial          = {rem_q, quo_q[WIDTH-1]};
    trial            = {1'b0, partial} - {2'b00, bmag_q};
    trial_ok         = ~trial[WIDTH+1];
    unused_trial_bit = trial[WIDTH];
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    ready_out = (state_q == S_IDLE);
    valid_out = valid_q;
    c_out     = c_q;
    r_out     = r_q;
`ifdef AP_DIV_ZERO_FLAG_EN
    dz_out    = dz_q;
`endif
  end

  // Datapath next values.
  always_comb begin
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    bmag_d  = bmag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    c_d     = c_q;
    r_d     = r_q;
    valid_d = 1'b0;
`ifdef AP_DIV_ZERO_FLAG_EN
    bzero_d = bzero_q;
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d  = CW'(WIDTH - 1);
          rem_d  = '0;
          quo_d  = a_mag;
          bmag_d = b_mag;
          // With a zero divisor the quotient stays all ones: suppressing
          // its negation leaves c=~0, while negating the remainder
          // restores r to the original dividend.
          qneg_d = (a_neg ^ b_neg) & ~b_zero;
          rneg_d = a_neg;
`ifdef AP_DIV_ZERO_FLAG_EN
          bzero_d = b_zero;
`endif
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (trial_ok) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = partial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
      end
      S_FIX: begin
        c_d     = qneg_q ? (~quo_q + 1'b1) : quo_q;
        r_d     = rneg_q ? (~rem_q + 1'b1) : rem_q;
        valid_d = 1'b1;
`ifdef AP_DIV_ZERO_FLAG_EN
        dz_d    = bzero_q;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      bmag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      c_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
`ifdef AP_DIV_ZERO_FLAG_EN
      bzero_q <= 1'b0;
      dz_q    <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      bmag_q  <= bmag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      c_q     <= c_d;
      r_q     <= r_d;
      valid_q <= valid_d;
`ifdef AP_DIV_ZERO_FLAG_EN
      bzero_q <= bzero_d;
      dz_q    <= dz_d;
`endif
    end
  end

endmodule
